// File: rtl/edge_window_pkg.sv
// ---------------------------------------------------------------------------
// edge_window_pkg
// Shared definitions for the edge-window sequencer:
//   - state_t   : FSM states of edge_window_ctrl (IDLE, RUN)
//   - EDGE_FELL : edge_sel encoding for a 1->0 check ($fell)
//   - EDGE_ROSE : edge_sel encoding for a 0->1 check ($rose)
//   - CW_DEFAULT / SW_DEFAULT : default counter and statistics widths
// ---------------------------------------------------------------------------
package edge_window_pkg;

  localparam int CW_DEFAULT = 8;
  localparam int SW_DEFAULT = 16;

  localparam logic EDGE_FELL = 1'b0;
  localparam logic EDGE_ROSE = 1'b1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/edge_window_det.sv
// ---------------------------------------------------------------------------
// edge_window_det
// Sampled-value edge detector. Keeps the previous sample of the monitored
// signal and flags a fell or rose edge between that sample and the current
// one, selected by the (already latched) edge_sel.
// Ports:
//   i_clk      : clock, posedge
//   i_rst      : synchronous active-high reset
//   i_sig_in   : monitored signal
//   i_edge_sel : EDGE_FELL or EDGE_ROSE
//   o_edge     : combinational edge flag for the current cycle
// ---------------------------------------------------------------------------
module edge_window_det
  import edge_window_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_sig_in,
  input  logic i_edge_sel,
  output logic o_edge
);

  logic r_prev;
  logic w_fell;
  logic w_rose;

  // The previous sample is refreshed every cycle. That covers both the
  // capture at window start and the per-cycle update while running, and it
  // keeps tracking through ignored early edges so a later edge can still hit.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= i_sig_in;
    end
  end

  assign w_fell = r_prev & ~i_sig_in;
  assign w_rose = ~r_prev & i_sig_in;

  // Pick the edge polarity the current window is checking for.
  always_comb begin
    o_edge = 1'b0;
    case (i_edge_sel)
      EDGE_FELL: o_edge = w_fell;
      EDGE_ROSE: o_edge = w_rose;
      default:   o_edge = 1'b0;
    endcase
  end

endmodule

// File: rtl/edge_window_ctrl.sv
// ---------------------------------------------------------------------------
// edge_window_ctrl
// Sequencer for checks of the form "edge of sig_in within ##[min:max] after
// start". A start pulse in IDLE arms a window; each RUN cycle the cycle index
// advances and the selected edge is evaluated. One verdict per window, with
// saturating pass/fail statistics.
// Build option:
//   EDGE_WINDOW_EARLY_FAIL_EN : an edge before the window opens fails the
//                               window instead of being ignored.
// Ports:
//   i_clk, i_rst      : clock (posedge), synchronous active-high reset
//   i_start, i_abort  : arm window (IDLE only) / cancel window, no verdict
//   i_edge_sel        : 0 = fell, 1 = rose, latched at start
//   i_cfg_min/max     : window bounds in cycles, latched at start
//   i_sig_in          : monitored signal
//   o_busy            : window running
//   o_done            : one-cycle verdict strobe
//   o_pass/o_fail     : verdict
//   o_cfg_err         : verdict caused by a bad configuration
//   o_hit_k           : index of the passing edge, 0 on fail
//   o_pass_cnt/o_fail_cnt : saturating statistics
// ---------------------------------------------------------------------------
module edge_window_ctrl
  import edge_window_pkg::*;
#(
  parameter int CW = CW_DEFAULT,
  parameter int SW = SW_DEFAULT
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic          i_abort,
  input  logic          i_edge_sel,
  input  logic [CW-1:0] i_cfg_min,
  input  logic [CW-1:0] i_cfg_max,
  input  logic          i_sig_in,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_pass,
  output logic          o_fail,
  output logic          o_cfg_err,
  output logic [CW-1:0] o_hit_k,
  output logic [SW-1:0] o_pass_cnt,
  output logic [SW-1:0] o_fail_cnt
);

  state_t        r_state;
  state_t        w_stateNext;

  logic          r_edgeSel;
  logic [CW-1:0] r_min;
  logic [CW-1:0] r_max;
  logic [CW-1:0] r_k;

  logic          r_done;
  logic          r_pass;
  logic          r_fail;
  logic          r_cfgErr;
  logic [CW-1:0] r_hitK;
  logic [SW-1:0] r_passCnt;
  logic [SW-1:0] r_failCnt;

  logic [CW-1:0] w_minEff;
  logic          w_cfgBad;
  logic [CW-1:0] w_kNext;
  logic          w_edge;

  logic          w_accept;
  logic          w_decide;
  logic          w_passV;
  logic          w_failV;
  logic          w_cfgErrV;
  logic [CW-1:0] w_hitV;

  // A minimum of 0 means "from the first cycle", so it is treated as 1.
  assign w_minEff = (i_cfg_min == '0) ? CW'(1) : i_cfg_min;
  assign w_cfgBad = (w_minEff > i_cfg_max) || (i_cfg_max == '0);
  assign w_kNext  = r_k + CW'(1);

  edge_window_det u_det (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_sig_in   (i_sig_in),
    .i_edge_sel (r_edgeSel),
    .o_edge     (w_edge)
  );

  // State register for the IDLE/RUN sequencer.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state and verdict decode. Abort wins over both start and any
  // decision in the same cycle. A bad configuration is judged right away at
  // the start edge without entering RUN. Because min <= max is guaranteed in
  // RUN, an early edge can never coincide with the timeout index.
  always_comb begin
    w_stateNext = r_state;
    w_accept    = 1'b0;
    w_decide    = 1'b0;
    w_passV     = 1'b0;
    w_failV     = 1'b0;
    w_cfgErrV   = 1'b0;
    w_hitV      = '0;
    case (r_state)
      IDLE: begin
        if (i_start && !i_abort) begin
          w_accept = 1'b1;
          if (w_cfgBad) begin
            w_decide  = 1'b1;
            w_failV   = 1'b1;
            w_cfgErrV = 1'b1;
          end else begin
            w_stateNext = RUN;
          end
        end
      end
      RUN: begin
        if (i_abort) begin
          w_stateNext = IDLE;
        end else if (w_edge && (w_kNext >= r_min)) begin
          w_decide = 1'b1;
          w_passV  = 1'b1;
          w_hitV   = w_kNext;
        end else if (w_kNext == r_max) begin
          w_decide = 1'b1;
          w_failV  = 1'b1;
`ifdef EDGE_WINDOW_EARLY_FAIL_EN
        end else if (w_edge) begin
          w_decide = 1'b1;
          w_failV  = 1'b1;
`endif
        end
        if (w_decide) begin
          w_stateNext = IDLE;
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  // Window configuration, cycle index, verdict registers and statistics.
  // Verdict fields only change on a decision so they hold between windows;
  // the counters stop at all-ones instead of wrapping.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_edgeSel <= EDGE_FELL;
      r_min     <= '0;
      r_max     <= '0;
      r_k       <= '0;
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
      r_fail    <= 1'b0;
      r_cfgErr  <= 1'b0;
      r_hitK    <= '0;
      r_passCnt <= '0;
      r_failCnt <= '0;
    end else begin
      r_done <= w_decide;
      if (w_accept) begin
        r_edgeSel <= i_edge_sel;
        r_min     <= w_minEff;
        r_max     <= i_cfg_max;
        r_k       <= '0;
      end else if (r_state == RUN) begin
        r_k <= w_kNext;
      end
      if (w_decide) begin
        r_pass   <= w_passV;
        r_fail   <= w_failV;
        r_cfgErr <= w_cfgErrV;
        r_hitK   <= w_hitV;
        if (w_passV && (r_passCnt != '1)) begin
          r_passCnt <= r_passCnt + SW'(1);
        end
        if (w_failV && (r_failCnt != '1)) begin
          r_failCnt <= r_failCnt + SW'(1);
        end
      end
    end
  end

  assign o_busy     = (r_state == RUN);
  assign o_done     = r_done;
  assign o_pass     = r_pass;
  assign o_fail     = r_fail;
  assign o_cfg_err  = r_cfgErr;
  assign o_hit_k    = r_hitK;
  assign o_pass_cnt = r_passCnt;
  assign o_fail_cnt = r_failCnt;

endmodule

// File: tb/tb_edge_window_ctrl.sv
// ---------------------------------------------------------------------------
// tb_edge_window_ctrl
// Directed bench for edge_window_ctrl (CW=8, SW=4 so saturation is reachable).
// Inputs change 1ns after a rising edge and outputs are checked there too,
// so every check sees the result of the edge just taken.
// Expectations follow EDGE_WINDOW_EARLY_FAIL_EN when it is defined.
// ---------------------------------------------------------------------------
module tb_edge_window_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       abort;
  logic       edgeSel;
  logic [7:0] cfgMin;
  logic [7:0] cfgMax;
  logic       sigIn;
  logic       busy;
  logic       done;
  logic       pass;
  logic       fail;
  logic       cfgErr;
  logic [7:0] hitK;
  logic [3:0] passCnt;
  logic [3:0] failCnt;

  int checks = 0;
  int errors = 0;

  int eBusy, eDone, ePass, eFail, eCfgErr, eHit, ePassCnt, eFailCnt;

  edge_window_ctrl #(.CW(8), .SW(4)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start),
    .i_abort    (abort),
    .i_edge_sel (edgeSel),
    .i_cfg_min  (cfgMin),
    .i_cfg_max  (cfgMax),
    .i_sig_in   (sigIn),
    .o_busy     (busy),
    .o_done     (done),
    .o_pass     (pass),
    .o_fail     (fail),
    .o_cfg_err  (cfgErr),
    .o_hit_k    (hitK),
    .o_pass_cnt (passCnt),
    .o_fail_cnt (failCnt)
  );

  // 10ns clock.
  always #5 clk = ~clk;

  // Safety net so the run always ends even if time stops advancing usefully.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setConfig(input logic sel, input int mn, input int mx);
    edgeSel = sel;
    cfgMin  = 8'(mn);
    cfgMax  = 8'(mx);
  endtask

  task automatic applyStimulus(input logic s, input logic a, input logic sig);
    start = s;
    abort = a;
    sigIn = sig;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".busy"},    32'(busy),    32'(eBusy));
    checkOutput({tag, ".done"},    32'(done),    32'(eDone));
    checkOutput({tag, ".pass"},    32'(pass),    32'(ePass));
    checkOutput({tag, ".fail"},    32'(fail),    32'(eFail));
    checkOutput({tag, ".cfgErr"},  32'(cfgErr),  32'(eCfgErr));
    checkOutput({tag, ".hitK"},    32'(hitK),    32'(eHit));
    checkOutput({tag, ".passCnt"}, 32'(passCnt), 32'(ePassCnt));
    checkOutput({tag, ".failCnt"}, 32'(failCnt), 32'(eFailCnt));
  endtask

  task automatic clearExpect();
    eBusy = 0; eDone = 0; ePass = 0; eFail = 0;
    eCfgErr = 0; eHit = 0; ePassCnt = 0; eFailCnt = 0;
  endtask

  initial begin
    clearExpect();
    rst = 1'b1;
    setConfig(1'b0, 0, 0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick();
    tick();
    checkAll("reset");
    rst = 1'b0;

    // Fell edge at index 3 inside [2:5].
    setConfig(1'b0, 2, 5);
    applyStimulus(1'b1, 1'b0, 1'b1);
    tick();
    eBusy = 1;
    checkAll("fell.t0");
    applyStimulus(1'b0, 1'b0, 1'b1);
    tick();
    tick();
    checkAll("fell.t2");
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick();
    eBusy = 0; eDone = 1; ePass = 1; eHit = 3; ePassCnt = 1;
    checkAll("fell.t3");
    tick();
    eDone = 0;
    checkAll("fell.hold");

    // Rose never happens in [1:4]: timeout at index 4. Start pulses with a
    // shorter max while running must not disturb the window.
    setConfig(1'b1, 1, 4);
    applyStimulus(1'b1, 1'b0, 1'b0);
    tick();
    eBusy = 1;
    checkAll("tmo.t0");
    setConfig(1'b1, 1, 2);
    applyStimulus(1'b1, 1'b0, 1'b0);
    tick();
    tick();
    checkAll("tmo.t2busyStart");
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick();
    checkAll("tmo.t3");
    tick();
    eBusy = 0; eDone = 1; ePass = 0; eFail = 1; eHit = 0; eFailCnt = 1;
    checkAll("tmo.t4");
    tick();
    eDone = 0;
    checkAll("tmo.hold");

    // Configuration errors: min > max, then max == 0 back-to-back.
    setConfig(1'b0, 5, 3);
    applyStimulus(1'b1, 1'b0, 1'b0);
    tick();
    eDone = 1; eFail = 1; eCfgErr = 1; eFailCnt = 2;
    checkAll("cfg.minGtMax");
    setConfig(1'b1, 0, 0);
    tick();
    eFailCnt = 3;
    checkAll("cfg.maxZero");
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick();
    eDone = 0;
    checkAll("cfg.idle");

    // Fell at index 2 in [4:6] is early.
    setConfig(1'b0, 4, 6);
    applyStimulus(1'b1, 1'b0, 1'b1);
    tick();
    eBusy = 1;
    checkAll("early.t0");
    applyStimulus(1'b0, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick();
`ifdef EDGE_WINDOW_EARLY_FAIL_EN
    eBusy = 0; eDone = 1; eFail = 1; eCfgErr = 0; eHit = 0; eFailCnt = 4;
    checkAll("early.t2fail");
    tick();
    eDone = 0;
    checkAll("early.hold");
`else
    checkAll("early.t2ignored");
    applyStimulus(1'b0, 1'b0, 1'b1);
    tick();
    tick();
    checkAll("early.t4");
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick();
    eBusy = 0; eDone = 1; ePass = 1; eFail = 0; eCfgErr = 0; eHit = 5;
    ePassCnt = 2;
    checkAll("early.t5pass");
    tick();
    eDone = 0;
    checkAll("early.hold");
`endif

    // Abort at t0+2 while a passing rose is present: no verdict.
    setConfig(1'b1, 1, 5);
    applyStimulus(1'b1, 1'b0, 1'b0);
    tick();
    eBusy = 1;
    checkAll("abort.t0");
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b1);
    tick();
    eBusy = 0;
    checkAll("abort.t2");
    applyStimulus(1'b0, 1'b0, 1'b1);
    tick();
    checkAll("abort.after");

    // Abort together with start in IDLE keeps the block idle.
    applyStimulus(1'b1, 1'b1, 1'b1);
    tick();
    checkAll("abortStart");
    applyStimulus(1'b0, 1'b0, 1'b1);
    tick();
    checkAll("abortStart.after");

    // Reset in the middle of a window clears everything.
    setConfig(1'b1, 1, 5);
    applyStimulus(1'b1, 1'b0, 1'b0);
    tick();
    eBusy = 1;
    checkAll("rst.t0");
    applyStimulus(1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    clearExpect();
    checkAll("rst.t1");
    rst = 1'b0;

    // Back-to-back one-cycle passes until pass_cnt saturates at 15.
    setConfig(1'b1, 1, 3);
    for (int i = 0; i < 17; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      tick();
      eBusy = 1; eDone = 0;
      checkAll("sat.start");
      applyStimulus(1'b0, 1'b0, 1'b1);
      tick();
      eBusy = 0; eDone = 1; ePass = 1; eFail = 0; eHit = 1;
      ePassCnt = (ePassCnt == 15) ? 15 : ePassCnt + 1;
      checkAll("sat.pass");
    end
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick();
    eDone = 0;
    checkAll("sat.hold");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/edge_window_ctrl.md
Name: edge_window_ctrl

Overview:
- Sequencer for sampled-value edge checks of the form "edge of sig_in within ##[cfg_min:cfg_max] after start".
- Arms a window on a start pulse, counts cycles, and evaluates $fell or $rose of sig_in each cycle.
- Issues one pass/fail verdict per window and keeps saturating pass/fail statistics.
- Sits between the assertion-sequence layer (issues start/abort) and the result/report logic.

Parameters:
- CW, 8, width of the cycle counter and of cfg_min/cfg_max/hit_k.
- SW, 16, width of the pass_cnt/fail_cnt statistics counters.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  arm-window pulse; honoured only in IDLE.
- abort  in  1  cancel the current window; no verdict is issued.
- edge_sel  in  1  0 = $fell (1→0), 1 = $rose (0→1); latched at start.
- cfg_min  in  CW  first valid cycle index; latched at start.
- cfg_max  in  CW  last valid cycle index; latched at start.
- sig_in  in  1  monitored signal.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle verdict strobe.
- pass  out  1  verdict: edge seen inside the window.
- fail  out  1  verdict: timeout, config error or early edge.
- cfg_err  out  1  verdict came from an invalid configuration.
- hit_k  out  CW  cycle index of the passing edge; 0 on fail.
- pass_cnt  out  SW  saturating count of passes.
- fail_cnt  out  SW  saturating count of fails.

Behaviour:
- Reset (rst=1 at posedge): state=IDLE. All outputs become 0, including both counters.
- FSM states: IDLE, RUN.
- IDLE, start=1 at posedge t0:
  - Latch edge_sel, cfg_min (a value of 0 is treated as 1) and cfg_max.
  - Set prev=sig_in and k=0.
  - If latched min > max, or cfg_max==0: stay IDLE and issue a verdict at t0 with fail=1, cfg_err=1.
  - Otherwise go to RUN.
- RUN, each posedge t:
  - k increments to k+1.
  - The edge is evaluated on (prev, sig_in), then prev is set to sig_in.
  - A fell edge is prev=1 and sig_in=0; a rose edge is prev=0 and sig_in=1.
- Decision at posedge t with index k+1:
  - edge and k+1 >= min: pass, hit_k=k+1.
  - No edge and k+1 == max: fail (timeout).
  - Edge and k+1 < min: ignored (see Optional Feature).
  - On any verdict, return to IDLE.
- Verdict timing:
  - done=1 for exactly the cycle after the deciding posedge.
  - pass, fail, hit_k and cfg_err are updated at that same posedge and hold until the next verdict or reset.
  - pass and fail are never both 1.
  - pass_cnt or fail_cnt increments by one at the deciding posedge and saturates at all-ones.
- Latency: a window of N cycles decides no later than posedge t0+N.
- A new start is accepted at the posedge after done (back-to-back windows allowed).
- start while busy: ignored, with no effect on the current window.
- abort (priority over start and over the decision in the same cycle): go to IDLE, no done, counters unchanged, verdict outputs unchanged.
- rst mid-window: immediate IDLE; all outputs cleared.
- The counter k never wraps, because the decision is forced at max.

Optional Feature:
- Macro: EDGE_WINDOW_EARLY_FAIL_EN.
- Defined: an edge at index < min yields fail=1, hit_k=0 and fail_cnt+1 at that posedge.
- Undefined: early edges are ignored, but prev still updates, so a later edge inside the window can still pass.

Decomposition:
- Package edge_window_pkg:
  - state enum (IDLE, RUN);
  - edge_sel encoding constants (EDGE_FELL=0, EDGE_ROSE=1);
  - default CW/SW localparams.
- One sub-module, edge_window_det: holds the prev register and produces the combinational fell/rose detect from edge_sel.
- The FSM, counters and verdict registers stay in the top module.

Test Plan:
- edge_sel=0, min=2, max=5, start at t0; sig_in 1 until it drops to 0 at t0+3 → done at t0+3, pass=1, hit_k=3, pass_cnt=1.
- edge_sel=1, min=1, max=4, sig_in held 0 → fail=1 decided at t0+4, hit_k=0, fail_cnt=1, no pass.
- min=5, max=3 → done at t0, fail=1, cfg_err=1, busy never asserted. Repeat with cfg_max=0 → same result.
- edge_sel=0, min=4, max=6, fell at t0+2:
  - Macro undefined: no verdict at t0+2; a re-rise then fell at t0+5 passes with hit_k=5.
  - Macro defined: fail at t0+2.
- Controls during a window:
  - start pulses while busy → ignored.
  - abort at t0+2 → IDLE, no done, counts unchanged.
  - abort and start in the same IDLE cycle → stays IDLE.
  - rst at t0+1 → all outputs 0.
- Force pass_cnt to its maximum via 2^SW passes (SW=4 build) → holds at 15. Back-to-back start the cycle after done is accepted.
